// File: rtl/fir_pkg.sv
// Shared defaults for the FIR averaging path and the width helper for tap sums.
package fir_pkg;

  localparam int DEF_TAP_SIZE = 4;
  localparam int DEF_WIDTH    = 4;
  localparam int DEF_DEPTH    = 4;

  // A sum of 'taps' unsigned w-bit samples needs log2(taps) extra bits.
  function automatic int sum_w(input int taps, input int w);
    return $clog2(taps) + w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered head, 0-cycle read visibility after write edge.
// Write while full is accepted only when a read frees a slot on the same edge.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int data_w = DEF_WIDTH,
  parameter int depth  = DEF_DEPTH,
  localparam int PTR_W = $clog2(depth),
  localparam int CNT_W = $clog2(depth) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [data_w-1:0] wr_dat,
  input  logic              rd_en,
  output logic [data_w-1:0] rd_dat,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [data_w-1:0] mem [depth];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_ok;
  logic              wr_ok;

  assign full   = (count == CNT_W'(depth));
  assign empty  = (count == '0);
  assign rd_ok  = rd_en & ~empty;
  assign wr_ok  = wr_en & (~full | rd_ok);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= (wr_ptr == PTR_W'(depth - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= (rd_ptr == PTR_W'(depth - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_avg_buffer.sv
// Rounds a FIR tap sum to a mean and buffers it; in_valid to out_valid is 2 edges.
// No upstream backpressure: a word arriving at a full FIFO with no read is dropped and flagged.
module fir_avg_buffer
  import fir_pkg::*;
#(
  parameter int tapSize = DEF_TAP_SIZE,
  parameter int width   = DEF_WIDTH,
  parameter int depth   = DEF_DEPTH,
  localparam int SUM_W  = sum_w(tapSize, width),
  localparam int CNT_W  = $clog2(depth) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [SUM_W-1:0]  in,
  input  logic              out_ready,
  input  logic              clear_ovf,
  output logic              out_valid,
  output logic [width-1:0]  out,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  localparam int               TAP_LOG2 = $clog2(tapSize);
  localparam logic [SUM_W-1:0] HALF     = SUM_W'(tapSize / 2);

  logic [SUM_W-1:0] sum_rnd;
  logic [width-1:0] avg;
  logic             s1_vld;
  logic [width-1:0] s1_dat;
  logic [width-1:0] head;
  logic             full;
  logic             empty;
  logic             rd_en;
  logic             drop;

  // A genuine tap sum is at most tapSize*(2^width-1), so adding half a tap never wraps.
  assign sum_rnd = in + HALF;
  assign avg     = width'(sum_rnd >> TAP_LOG2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_dat <= avg;
      end
    end
  end

  sync_fifo #(
    .data_w(width),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (s1_vld),
    .wr_dat(s1_dat),
    .rd_en (rd_en),
    .rd_dat(head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign out_valid = ~empty;
  assign rd_en     = out_valid & out_ready;
  // Gating on out_valid keeps out at 0 whenever nothing is buffered, including in reset.
  assign out       = out_valid ? head : '0;
  assign drop      = s1_vld & full & ~rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_avg_buffer.sv
// Directed bench for fir_avg_buffer at tapSize=4, width=4, depth=4.
module tb_fir_avg_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [5:0] in;
  logic       out_ready;
  logic       clear_ovf;
  logic       out_valid;
  logic [3:0] out;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  fir_avg_buffer #(.tapSize(4), .width(4), .depth(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in),
    .out_ready (out_ready),
    .clear_ovf (clear_ovf),
    .out_valid (out_valid),
    .out       (out),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] v);
    in       = v;
    in_valid = 1'b1;
    step();
  endtask

  logic [5:0] seq_in  [4];
  logic [3:0] seq_out [6];
  logic       seq_vld [6];

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in        = '0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out", out, 0);
    step();
    step();
    @(negedge clk);
    reset = 1'b0;

    // Single sample: 60 rounds to 15, visible for one cycle two edges later
    out_ready = 1'b1;
    send(6'd60);
    in_valid = 1'b0;
    check("single_e1_vld", out_valid, 0);
    step();
    check("single_e2_vld", out_valid, 1);
    check("single_e2_out", out, 15);
    check("single_e2_cnt", fifo_count, 1);
    step();
    check("single_e3_vld", out_valid, 0);
    check("single_e3_cnt", fifo_count, 0);
    step();
    check("ready_empty_cnt", fifo_count, 0);

    // Back-to-back stream with rounding half up
    seq_in  = '{6'd6, 6'd5, 6'd2, 6'd1};
    seq_vld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    seq_out = '{4'd0, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in       = seq_in[i];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      check($sformatf("stream_vld%0d", i), out_valid, seq_vld[i]);
      if (seq_vld[i]) check($sformatf("stream_out%0d", i), out, seq_out[i]);
    end

    // Fill with no reader: fifth word dropped
    out_ready = 1'b0;
    send(6'd4);
    send(6'd8);
    send(6'd12);
    send(6'd16);
    send(6'd20);
    in_valid = 1'b0;
    step();
    check("fill_cnt", fifo_count, 4);
    check("fill_ovf", overflow, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_out%0d", i), out, i);
      step();
    end
    check("drain_empty", out_valid, 0);
    check("drain_cnt", fifo_count, 0);

    // Clear without a drop
    out_ready = 1'b0;
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("clear_ovf", overflow, 0);

    // Full with simultaneous read and write
    send(6'd4);
    send(6'd8);
    send(6'd12);
    send(6'd16);
    send(6'd20);
    check("full_cnt", fifo_count, 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("rw_full_cnt", fifo_count, 4);
    check("rw_full_out", out, 2);
    check("rw_full_ovf", overflow, 0);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("rw_drain_out%0d", i), out, i);
      step();
    end
    check("rw_drain_empty", out_valid, 0);

    // Drop and clear on the same edge: set wins
    out_ready = 1'b0;
    send(6'd4);
    send(6'd8);
    send(6'd12);
    send(6'd16);
    send(6'd20);
    send(6'd24);
    check("ovf_set", overflow, 1);
    in_valid  = 1'b0;
    clear_ovf = 1'b1;
    step();
    check("ovf_set_wins", overflow, 1);
    step();
    clear_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    check("ovf_cnt", fifo_count, 4);

    // Mid-cycle reset with three words buffered and one in flight
    out_ready = 1'b1;
    send(6'd8);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("pre_rst_cnt", fifo_count, 3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_vld", out_valid, 0);
    check("async_rst_cnt", fifo_count, 0);
    check("async_rst_out", out, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_rst_inflight", out_valid, 0);
    check("post_rst_inflight_cnt", fifo_count, 0);
    send(6'd40);
    in_valid = 1'b0;
    step();
    check("post_rst_vld", out_valid, 1);
    check("post_rst_out", out, 10);
    check("post_rst_cnt", fifo_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_avg_buffer.md
FIR_AVG_BUFFER -- requirements
Module: fir_avg_buffer

Interface
REQ-001 Parameter tapSize, default 4, FIR tap count; power of two, at least 2.
REQ-002 Parameter width, default 4, FIR sample width and output word width.
REQ-003 Parameter depth, default 4, output FIFO depth; power of two, at least 2.
REQ-004 Derived constant SUM_W = $clog2(tapSize)+width, the input sum width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream FIR sum valid; no backpressure path exists upstream.
REQ-008 in  input  SUM_W  unsigned FIR tap sum.
REQ-009 out_ready  input  1  downstream ready to accept a word.
REQ-010 clear_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-011 out_valid  output  1  FIFO head holds a valid averaged word.
REQ-012 out  output  width  averaged word at the FIFO head.
REQ-013 fifo_count  output  $clog2(depth)+1  number of words stored.
REQ-014 overflow  output  1  sticky flag: at least one sample dropped.

Function
REQ-015 Stage 1 computes avg = (in + tapSize/2) >> $clog2(tapSize), rounding half up, and registers avg with a valid bit when in_valid=1.
REQ-016 The stage-1 sum uses SUM_W bits, needs no saturation, and keeps the result within width bits by construction.
REQ-017 The stage-1 valid bit clears on any cycle with in_valid=0, so stage 1 holds no stale data.
REQ-018 The FIFO writes a stage-1 word on the next edge: an in_valid at edge N gives out_valid=1 after edge N+1 when the FIFO was empty.
REQ-019 A read occurs on an edge where out_valid=1 and out_ready=1; out then advances to the next word, or out_valid falls if the FIFO is empty.
REQ-020 out and out_valid are driven from registers or FIFO storage, with no combinational path from in or in_valid.
REQ-021 Simultaneous read and write with the FIFO neither empty nor full: both occur and fifo_count is unchanged.
REQ-022 Write while full with a read on the same edge: the write is accepted and fifo_count stays at depth.
REQ-023 Write while full without a read: the word is dropped, FIFO contents and fifo_count are unchanged, and overflow is set.
REQ-024 Write and read pointers each wrap from depth-1 to 0; fifo_count never exceeds depth and never goes below 0.
REQ-025 overflow stays set until clear_ovf=1; if a drop and clear_ovf occur on the same edge, overflow is 1 (set wins).
REQ-026 out_ready=1 while the FIFO is empty has no effect.

Reset
REQ-027 Asserting reset immediately sets pointers, fifo_count, the stage-1 valid bit, out_valid and overflow to 0, regardless of clk.
REQ-028 While reset is high, out reads 0.
REQ-029 Reset during operation discards all buffered and in-flight words; the first in_valid after reset is treated as the first sample.
REQ-030 After reset deasserts, the first sample is accepted on the next rising edge.

Structure
REQ-031 The shared package fir_pkg holds the default tapSize, width and depth constants and the SUM_W width function; the block uses them.
REQ-032 The FIFO is a single sub-module, sync_fifo, parameterised by data width and depth, exposing wr_en, rd_en, full, empty and count.
REQ-033 Rounding logic and overflow-flag logic stay in fir_avg_buffer.

Verification (tapSize=4, width=4, depth=4)
REQ-034 in=60, in_valid for 1 cycle, out_ready=1 -> out=15 with out_valid=1 for exactly 1 cycle, 2 edges after input.
REQ-035 in sequence 6, 5, 2, 1 on consecutive cycles, out_ready=1 -> out sequence 2, 1, 1, 0 in order, no gaps.
REQ-036 out_ready=0, 5 consecutive samples 4, 8, 12, 16, 20 -> fifo_count=4, overflow=1; draining yields 1, 2, 3, 4, and 5 is lost.
REQ-037 FIFO full, out_ready=1 and in_valid=1 on the same edge -> head pops, new word is stored, fifo_count stays 4, overflow stays 0.
REQ-038 overflow=1, a drop and clear_ovf=1 on the same edge -> overflow=1; clear_ovf with no drop -> overflow=0 on the next edge.
REQ-039 Reset asserted mid-edge with 3 words buffered -> out_valid=0 and fifo_count=0 immediately; the next sample in=40 -> out=10.
